// File: rtl/serial_rx.sv
// UART receiver with a small read FIFO and STATUS register on the CPU data bus.
// Define SERIAL_RX_PARITY_EN for 8E1 frames; the default build receives 8N1.
module serial_rx #(
  parameter int CLK_FREQ = 10000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 8
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        rxd,
  input  logic        sel,
  input  logic        re,
  input  logic [2:0]  addr,
  output logic [31:0] dout
);

  localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int          AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [4:0]  DEPTH_C      = 5'(DEPTH);

  // Returns 1 when data plus parity bit do not have an even number of ones.
  function automatic logic even_parity_bad(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SERIAL_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BRK    = 3'd5
  } state_t;

  logic        sync1_r, sync2_r, prev_r;
  logic        fall_s;
  state_t      state_r, state_n;
  logic [15:0] cnt_r, cnt_n;
  logic [2:0]  bit_r, bit_n;
  logic [7:0]  shift_r, shift_n;
  logic        push_s, frame_err_set_s;
  logic        parity_err_s;

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wptr_r, rptr_r;
  logic [4:0]    count_r;
  logic          full_s, nonempty_s, pop_s, push_ok_s, overrun_set_s, stat_rd_s;
  logic          overrun_r, frame_err_r;
  logic [3:0]    count_field_s;
  logic          unused_s;

`ifdef SERIAL_RX_PARITY_EN
  logic pbad_r, pbad_n, parity_err_set_s, parity_err_r;
`endif

  assign unused_s = ^addr[1:0];
  assign fall_s   = prev_r & ~sync2_r;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rxd;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Receive FSM next-state and datapath decisions.
  always_comb begin
    state_n         = state_r;
    cnt_n           = cnt_r;
    bit_n           = bit_r;
    shift_n         = shift_r;
    push_s          = 1'b0;
    frame_err_set_s = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    pbad_n           = pbad_r;
    parity_err_set_s = 1'b0;
`endif
    case (state_r)
      S_IDLE: begin
        if (fall_s) begin
          state_n = S_START;
          cnt_n   = 16'd0;
          bit_n   = 3'd0;
`ifdef SERIAL_RX_PARITY_EN
          pbad_n  = 1'b0;
`endif
        end else begin
          state_n = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_n = 16'd0;
          if (!sync2_r) begin
            state_n = S_DATA;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt_r + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_n   = 16'd0;
          shift_n = {sync2_r, shift_r[7:1]};
          if (bit_r == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_n = bit_r + 3'd1;
          end
        end else begin
          cnt_n = cnt_r + 16'd1;
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_r == BIT_LAST) begin
          cnt_n            = 16'd0;
          pbad_n           = even_parity_bad(shift_r, sync2_r);
          parity_err_set_s = pbad_n;
          state_n          = S_STOP;
        end else begin
          cnt_n = cnt_r + 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_n = 16'd0;
          if (sync2_r) begin
`ifdef SERIAL_RX_PARITY_EN
            push_s = ~pbad_r;
`else
            push_s = 1'b1;
`endif
            state_n = S_IDLE;
          end else begin
            frame_err_set_s = 1'b1;
            state_n         = S_BRK;
          end
        end else begin
          cnt_n = cnt_r + 16'd1;
        end
      end
      S_BRK: begin
        if (sync2_r) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_BRK;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Receive FSM state and datapath registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r <= S_IDLE;
      cnt_r   <= 16'd0;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      bit_r   <= bit_n;
      shift_r <= shift_n;
    end
  end

  assign full_s        = (count_r == DEPTH_C);
  assign nonempty_s    = (count_r != 5'd0);
  assign pop_s         = sel & re & ~addr[2] & nonempty_s;
  assign stat_rd_s     = sel & re & addr[2];
  // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
  assign push_ok_s     = push_s & (~full_s | pop_s);
  assign overrun_set_s = push_s & full_s & ~pop_s;
  assign count_field_s = (count_r > 5'd15) ? 4'd15 : count_r[3:0];

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'd0;
      end
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= 5'd0;
    end else begin
      if (push_ok_s) begin
        mem_r[wptr_r] <= shift_r;
        wptr_r        <= wptr_r + 1'b1;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + 1'b1;
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + 5'd1;
        2'b01:   count_r <= count_r - 5'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky error flags: a set event wins over a same-cycle STATUS read clear.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      overrun_r   <= overrun_set_s   | (overrun_r   & ~stat_rd_s);
      frame_err_r <= frame_err_set_s | (frame_err_r & ~stat_rd_s);
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  // Parity flag and the per-frame discard marker.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pbad_r       <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      pbad_r       <= pbad_n;
      parity_err_r <= parity_err_set_s | (parity_err_r & ~stat_rd_s);
    end
  end
  assign parity_err_s = parity_err_r;
`else
  assign parity_err_s = 1'b0;
`endif

  // Register read mux.
  always_comb begin
    dout = 32'd0;
    case (addr[2])
      1'b0: begin
        if (nonempty_s) begin
          dout = {23'd0, 1'b1, mem_r[rptr_r]};
        end else begin
          dout = 32'd0;
        end
      end
      1'b1: dout = {20'd0, count_field_s, 3'd0, parity_err_s, frame_err_r,
                    overrun_r, full_s, nonempty_s};
      default: dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_serial_rx.sv
// Directed self-checking bench for serial_rx at the default 86 clocks per bit.
`timescale 1ns/1ps
module tb_serial_rx;

  logic        clk;
  logic        clrn;
  logic        rxd;
  logic        sel;
  logic        re;
  logic [2:0]  addr;
  logic [31:0] dout;

  int vectors;
  int miscompares;
`ifdef SERIAL_RX_PARITY_EN
  logic force_par_bad;
`endif

  localparam int BIT = 86;

  serial_rx dut (
    .clk  (clk),
    .clrn (clrn),
    .rxd  (rxd),
    .sel  (sel),
    .re   (re),
    .addr (addr),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic send_frame(input logic [7:0] d, input logic stop_lvl);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef SERIAL_RX_PARITY_EN
    rxd = (^d) ^ force_par_bad;
    repeat (BIT) @(negedge clk);
`endif
    rxd = stop_lvl;
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic bus_read(input logic is_status, output logic [31:0] v);
    @(negedge clk);
    sel  = 1'b1;
    re   = 1'b1;
    addr = {is_status, 2'b00};
    #1 v = dout;
    @(negedge clk);
    sel = 1'b0;
    re  = 1'b0;
  endtask

  task automatic peek(input logic is_status, output logic [31:0] v);
    @(negedge clk);
    addr = {is_status, 2'b00};
    #1 v = dout;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    peek(1'b0, v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected %h", v, 32'h0);
    end
    peek(1'b1, v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_status: got %h expected %h", v, 32'h0);
    end
    clrn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    logic [31:0] v;
    send_frame(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(1'b1, v);
    vectors++;
    if (v !== 32'h00000101) begin
      miscompares++;
      $display("FAIL single_status: got %h expected %h", v, 32'h00000101);
    end
    bus_read(1'b0, v);
    vectors++;
    if (v !== 32'h000001A5) begin
      miscompares++;
      $display("FAIL single_data: got %h expected %h", v, 32'h000001A5);
    end
    bus_read(1'b1, v);
    vectors++;
    if (v !== 32'h00000000) begin
      miscompares++;
      $display("FAIL single_status_after: got %h expected %h", v, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b1);
    end
    repeat (4) @(negedge clk);
    bus_read(1'b1, v);
    vectors++;
    if (v !== 32'h00000807) begin
      miscompares++;
      $display("FAIL overrun_status: got %h expected %h", v, 32'h00000807);
    end
    for (int i = 1; i <= 8; i++) begin
      bus_read(1'b0, v);
      vectors++;
      if (v !== (32'h100 + 32'(i))) begin
        miscompares++;
        $display("FAIL fifo_data_%0d: got %h expected %h", i, v, 32'h100 + 32'(i));
      end
    end
    bus_read(1'b0, v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL empty_pop: got %h expected %h", v, 32'h0);
    end
    peek(1'b1, v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL empty_status: got %h expected %h", v, 32'h0);
    end
  endtask

  task automatic test_frame_err();
    logic [31:0] v;
    send_frame(8'h3C, 1'b0);
    repeat (200) @(negedge clk);
    bus_read(1'b1, v);
    vectors++;
    if (v !== 32'h00000008) begin
      miscompares++;
      $display("FAIL frame_err_status: got %h expected %h", v, 32'h00000008);
    end
    send_frame(8'h55, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(1'b1, v);
    vectors++;
    if (v !== 32'h00000101) begin
      miscompares++;
      $display("FAIL after_ferr_status: got %h expected %h", v, 32'h00000101);
    end
    bus_read(1'b0, v);
    vectors++;
    if (v !== 32'h00000155) begin
      miscompares++;
      $display("FAIL after_ferr_data: got %h expected %h", v, 32'h00000155);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] v;
    @(negedge clk);
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    rxd = 1'b1;
    repeat (1200) @(negedge clk);
    peek(1'b1, v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL glitch_status: got %h expected %h", v, 32'h0);
    end
    send_frame(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(1'b0, v);
    vectors++;
    if (v !== 32'h00000181) begin
      miscompares++;
      $display("FAIL glitch_recover_data: got %h expected %h", v, 32'h00000181);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    logic [31:0] v_in_rst;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (BIT * 5 + 43) @(negedge clk);
        clrn = 1'b0;
        #1 v_in_rst = dout;
        repeat (3) @(negedge clk);
        clrn = 1'b1;
      end
    join
    vectors++;
    if (v_in_rst !== 32'h0) begin
      miscompares++;
      $display("FAIL midframe_in_reset: got %h expected %h", v_in_rst, 32'h0);
    end
    repeat (200) @(negedge clk);
    peek(1'b1, v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL midframe_no_push: got %h expected %h", v, 32'h0);
    end
    send_frame(8'h12, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(1'b1, v);
    vectors++;
    if (v !== 32'h00000101) begin
      miscompares++;
      $display("FAIL midframe_status: got %h expected %h", v, 32'h00000101);
    end
    bus_read(1'b0, v);
    vectors++;
    if (v !== 32'h00000112) begin
      miscompares++;
      $display("FAIL midframe_data: got %h expected %h", v, 32'h00000112);
    end
  endtask

`ifdef SERIAL_RX_PARITY_EN
  task automatic test_parity();
    logic [31:0] v;
    force_par_bad = 1'b1;
    send_frame(8'h07, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(1'b1, v);
    vectors++;
    if (v !== 32'h00000010) begin
      miscompares++;
      $display("FAIL parity_err_status: got %h expected %h", v, 32'h00000010);
    end
    force_par_bad = 1'b0;
    send_frame(8'h07, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(1'b1, v);
    vectors++;
    if (v !== 32'h00000101) begin
      miscompares++;
      $display("FAIL parity_ok_status: got %h expected %h", v, 32'h00000101);
    end
    bus_read(1'b0, v);
    vectors++;
    if (v !== 32'h00000107) begin
      miscompares++;
      $display("FAIL parity_ok_data: got %h expected %h", v, 32'h00000107);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    rxd         = 1'b1;
    sel         = 1'b0;
    re          = 1'b0;
    addr        = 3'd0;
    clrn        = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    force_par_bad = 1'b0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_reset_midframe();
`ifdef SERIAL_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
